// File: rtl/tdm_demux_pkg.sv
// Shared types and helpers for the TDM sample demultiplexer.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package tdm_demux_pkg;

    localparam int N_LANES_DEF = 8;
    localparam int W_DEF       = 4;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Next slot index, wrapping from n-1 back to 0.
    function automatic int unsigned slot_next(input int unsigned slot, input int unsigned n);
        return (slot == n - 1) ? 32'd0 : slot + 32'd1;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter: holds the slot index the next accepted beat will occupy.
// Latency: registered, new value one clock after inc/load_one/clear.
// Backpressure: none; holds its value when no control input is asserted.
module tdm_slot_ctr
    import tdm_demux_pkg::*;
#(
    parameter int N = N_LANES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load_one,
    input  logic                 inc,
    output logic [$clog2(N)-1:0] slot,
    output logic                 is_last
);
    localparam int SW = $clog2(N);

    // Priority: clear, then resync to slot 1, then normal advance with wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (clear) begin
            slot <= '0;
        end else if (load_one) begin
            slot <= SW'(1);
        end else if (inc) begin
            slot <= SW'(slot_next(32'(slot), N));
        end
    end

    assign is_last = (slot == SW'(N - 1));

endmodule

// File: rtl/tdm_demux8.sv
// TDM demultiplexer: one W-bit sample per slot, N slots per frame, committed coherently to N lanes.
// Latency: lanes/frame_done update 1 clock after the slot N-1 beat (last sample bypassed).
// Backpressure: none; in_valid=0 beats are ignored and the slot counter holds.
// Optional build macro TDM_DEMUX_PARITY_EN adds in_parity/par_err and drops frames with bad parity.
module tdm_demux8
    import tdm_demux_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_LANES_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic           in_sync,
    input  logic [W-1:0]   in_data,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic           in_parity,
    output logic           par_err,
`endif
    output logic [N*W-1:0] lanes,
    output logic           frame_done,
    output logic           locked,
    output logic           sync_err
);
    localparam int SW = $clog2(N);

    state_t         state;
    logic [W-1:0]   shadow [N];
    logic [SW-1:0]  slot;
    logic           slot_last;

    logic           hunt_hit;
    logic           lock_beat;
    logic           misalign;
    logic           slot0_load;
    logic           wr_en;
    logic [SW-1:0]  wr_idx;
    logic           commit_ok;
    logic           commit;

    // A sync in HUNT starts a frame; a sync off slot 0 in LOCK restarts one.
    assign hunt_hit   = (state == HUNT) && in_valid && in_sync;
    assign lock_beat  = (state == LOCK) && in_valid;
    assign misalign   = lock_beat && in_sync && (slot != '0);
    assign slot0_load = hunt_hit || misalign;

    assign wr_en  = slot0_load || lock_beat;
    assign wr_idx = slot0_load ? '0 : slot;

`ifdef TDM_DEMUX_PARITY_EN
    logic par_bad;
    logic frame_bad;

    // Even parity: in_parity must equal the XOR of the data bits.
    assign par_bad   = in_valid && (in_parity != (^in_data));
    assign commit_ok = !frame_bad && !par_bad;

    // Sticky per-frame parity flag, restarted on every slot-0 beat, cleared at wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_bad <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            par_err <= par_bad;
            if (slot0_load || (lock_beat && slot == '0)) begin
                frame_bad <= par_bad;
            end else if (lock_beat && slot_last) begin
                frame_bad <= 1'b0;
            end else if (lock_beat) begin
                frame_bad <= frame_bad | par_bad;
            end
        end
    end
`else
    assign commit_ok = 1'b1;
`endif

    // A misaligned sync on slot N-1 is a restart, never a commit.
    assign commit = lock_beat && !misalign && slot_last && commit_ok;

    tdm_slot_ctr #(
        .N (N)
    ) u_slot_ctr (
        .clk      (clk),
        .rst      (rst),
        .clear    ((state == HUNT) && !hunt_hit),
        .load_one (slot0_load),
        .inc      (lock_beat && !misalign),
        .slot     (slot),
        .is_last  (slot_last)
    );

    // Gather samples into the shadow buffer at their slot position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                shadow[k] <= '0;
            end
        end else if (wr_en) begin
            shadow[wr_idx] <= in_data;
        end
    end

    // Commit the whole frame at once; the last sample bypasses the shadow buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= commit;
            if (commit) begin
                for (int k = 0; k < N - 1; k++) begin
                    lanes[k*W +: W] <= shadow[k];
                end
                lanes[(N-1)*W +: W] <= in_data;
            end
        end
    end

    // Alignment FSM: HUNT until the first sync, then LOCK until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= misalign;
            if (hunt_hit) begin
                state  <= LOCK;
                locked <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux8.sv
module tb_tdm_demux8;
    localparam int W = 4;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_sync;
    logic [W-1:0]   in_data;
    logic [N*W-1:0] lanes;
    logic           frame_done;
    logic           locked;
    logic           sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic           in_parity;
    logic           par_err;
    logic           force_bad = 1'b0;
`endif

    tdm_demux8 #(.W(W), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sync    (in_sync),
        .in_data    (in_data),
`ifdef TDM_DEMUX_PARITY_EN
        .in_parity  (in_parity),
        .par_err    (par_err),
`endif
        .lanes      (lanes),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard queues: expected commits (lanes + cycle) and expected pulse cycles.
    typedef struct {
        logic [N*W-1:0] lanes;
        int             when;
    } commit_t;

    commit_t cq[$];
    int      sq[$];
    int      pq[$];
    commit_t ce;
    int      pe;

    // Monitor: pops and compares whenever the DUT presents a pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) begin
                if (cq.size() == 0) begin
                    check("unexpected_frame_done", frame_done, 0);
                end else begin
                    ce = cq.pop_front();
                    check("commit_lanes", lanes, ce.lanes);
                    check("commit_cycle", cyc, ce.when);
                end
            end
            if (sync_err) begin
                if (sq.size() == 0) begin
                    check("unexpected_sync_err", sync_err, 0);
                end else begin
                    pe = sq.pop_front();
                    check("sync_err_cycle", cyc, pe);
                end
            end
`ifdef TDM_DEMUX_PARITY_EN
            if (par_err) begin
                if (pq.size() == 0) begin
                    check("unexpected_par_err", par_err, 0);
                end else begin
                    pe = pq.pop_front();
                    check("par_err_cycle", cyc, pe);
                end
            end
`endif
        end
    end

    // One beat; inputs change at a falling edge, sampled at the next rising edge.
    task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
        in_valid = v;
        in_sync  = s;
        in_data  = d;
`ifdef TDM_DEMUX_PARITY_EN
        in_parity = (^d) ^ force_bad;
`endif
        @(negedge clk);
    endtask

    // Eight beats, optional idle gap before beat gap_at; commit expected N+gaps cycles after start.
    task automatic send_frame(input logic [N*W-1:0] vals, input bit sync0, input int gap_at,
                              input int gaps, input logic [N*W-1:0] exp_lanes, input bit exp_commit);
        commit_t c;
        int t0;
        t0 = cyc;
        for (int i = 0; i < N; i++) begin
            if (i == gap_at) repeat (gaps) drive(1'b0, 1'b0, 4'h0);
            if (i == N - 1 && exp_commit) begin
                c.lanes = exp_lanes;
                c.when  = t0 + N + gaps;
                cq.push_back(c);
            end
            drive(1'b1, sync0 && (i == 0), vals[i*W +: W]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_sync = 1'b0;
        in_data = '0;
`ifdef TDM_DEMUX_PARITY_EN
        in_parity = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_lanes", lanes, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_locked", locked, 0);
        check("reset_sync_err", sync_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Aligned frame 0..7; locked one beat after the sync beat.
        drive(1'b1, 1'b1, 4'h0);
        check("locked_after_beat1", locked, 1);
        for (int i = 1; i < N; i++) begin
            if (i == N - 1) begin
                ce.lanes = 32'h76543210;
                ce.when  = cyc + 1;
                cq.push_back(ce);
            end
            drive(1'b1, 1'b0, 4'(i));
        end
        drive(1'b0, 1'b0, 4'h0);
        check("lanes_aligned", lanes, 32'h76543210);

        // Same frame, 3 idle cycles between beats 3 and 4: commit 3 cycles later.
        send_frame(32'h76543210, 1'b1, 4, 3, 32'h76543210, 1'b1);
        drive(1'b0, 1'b0, 4'h0);

        // Back-to-back frames, second without sync.
        send_frame(32'hFEDCBA98, 1'b1, -1, 0, 32'hFEDCBA98, 1'b1);
        send_frame(32'h01234567, 1'b0, -1, 0, 32'h01234567, 1'b1);
        check("lanes_b2b", lanes, 32'h01234567);

        // Misaligned sync on slot 5: partial frame dropped, restart committed.
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 4'h9);
        sq.push_back(cyc + 1);
        drive(1'b1, 1'b1, 4'hF);
        check("lanes_hold_misalign", lanes, 32'h01234567);
        check("locked_after_misalign", locked, 1);
        for (int i = 1; i < N; i++) begin
            if (i == N - 1) begin
                ce.lanes = 32'h89ABCDEF;
                ce.when  = cyc + 1;
                cq.push_back(ce);
            end
            drive(1'b1, 1'b0, 4'(4'hF - i));
        end
        drive(1'b0, 1'b0, 4'h0);
        check("lanes_after_resync", lanes, 32'h89ABCDEF);

        // Misaligned sync exactly on slot N-1: restart, no commit.
        for (int i = 0; i < N - 1; i++) drive(1'b1, i == 0, 4'h4);
        sq.push_back(cyc + 1);
        send_frame(32'h33333333, 1'b1, -1, 0, 32'h33333333, 1'b1);
        check("lanes_last_slot_resync", lanes, 32'h33333333);

        // Reset mid-frame, asserted between clock edges.
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 4'h6);
        #2 rst = 1'b1;
        #1;
        check("midrst_lanes", lanes, 0);
        check("midrst_locked", locked, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_sync_err", sync_err, 0);
        @(negedge clk);
        rst = 1'b0;

        // HUNT discards unsynced beats, including a full unsynced frame.
        drive(1'b1, 1'b0, 4'hA);
        drive(1'b1, 1'b0, 4'hB);
        check("hunt_locked", locked, 0);
        check("hunt_lanes", lanes, 0);
        send_frame(32'h55555555, 1'b0, -1, 0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 4'h0);
        check("hunt_no_commit_lanes", lanes, 0);
        check("hunt_still_unlocked", locked, 0);
        send_frame(32'h11111111, 1'b1, -1, 0, 32'h11111111, 1'b1);
        drive(1'b0, 1'b0, 4'h0);
        check("lanes_after_hunt", lanes, 32'h11111111);

`ifdef TDM_DEMUX_PARITY_EN
        // Bad parity on beat 2: par_err pulse, frame dropped, next clean frame commits.
        for (int i = 0; i < N; i++) begin
            force_bad = (i == 2);
            if (i == 2) pq.push_back(cyc + 1);
            drive(1'b1, i == 0, 4'hC);
        end
        force_bad = 1'b0;
        drive(1'b0, 1'b0, 4'h0);
        check("par_lanes_hold", lanes, 32'h11111111);
        send_frame(32'h22222222, 1'b1, -1, 0, 32'h22222222, 1'b1);
        drive(1'b0, 1'b0, 4'h0);
        check("par_clean_commit", lanes, 32'h22222222);
`endif

        repeat (4) drive(1'b0, 1'b0, 4'h0);
        check("commits_outstanding", cq.size(), 0);
        check("sync_err_outstanding", sq.size(), 0);
        check("par_err_outstanding", pq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
